codifica_hamming_serial: RTL

Upstream stage of the Hamming(15,11) correction path. Accepts 11-bit data words over a valid/ready handshake and encodes each into the 15-bit codeword layout the corrector expects, with parity at indices 14, 13, 11 and 7. It serialises the codeword MSB-first onto a one-bit link, framed by a start strobe. It also presents the full codeword in parallel for loopback checks.

---
 rtl/hamming_pkg.sv | 18 +
 rtl/gera_hamming.sv | 26 ++
 rtl/codifica_hamming_serial.sv | 88 ++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared constants and FSM state type for the Hamming(15,11) encode/correct path.
package hamming_pkg;

  localparam int LARG_DADO   = 11;
  localparam int LARG_CODIGO = 15;

  // Parity positions in the 15-bit layout the corrector expects.
  localparam int PAR0 = 14;
  localparam int PAR1 = 13;
  localparam int PAR2 = 11;
  localparam int PAR3 = 7;

  typedef enum logic [0:0] {
    OCIOSO    = 1'b0,
    TRANSMITE = 1'b1
  } estado_tx_t;

endpackage

// File: rtl/gera_hamming.sv
// Combinational Hamming(15,11) encoder: places the 11 data bits and computes
// the four parity bits. Purely combinational so it can double as a reference model.
module gera_hamming
  import hamming_pkg::*;
(
  input  logic [LARG_DADO-1:0]   i_dado,
  output logic [LARG_CODIGO-1:0] o_codigo
);

  logic [LARG_CODIGO-1:0] w_cw;

  always_comb begin
    w_cw       = '0;
    w_cw[12]   = i_dado[10];
    w_cw[10:8] = i_dado[9:7];
    w_cw[6:0]  = i_dado[6:0];
    // Parity is computed from the data positions placed above.
    w_cw[PAR0] = w_cw[12] ^ w_cw[10] ^ w_cw[8] ^ w_cw[6] ^ w_cw[4] ^ w_cw[2] ^ w_cw[0];
    w_cw[PAR1] = w_cw[12] ^ w_cw[9]  ^ w_cw[8] ^ w_cw[5] ^ w_cw[4] ^ w_cw[1] ^ w_cw[0];
    w_cw[PAR2] = w_cw[10] ^ w_cw[9]  ^ w_cw[8] ^ w_cw[3] ^ w_cw[2] ^ w_cw[1] ^ w_cw[0];
    w_cw[PAR3] = w_cw[6]  ^ w_cw[5]  ^ w_cw[4] ^ w_cw[3] ^ w_cw[2] ^ w_cw[1] ^ w_cw[0];
  end

  assign o_codigo = w_cw;

endmodule

// File: rtl/codifica_hamming_serial.sv
// Hamming(15,11) encoder with MSB-first serial link and parallel codeword output.
// Define CODIFICA_INJETA_ERRO_EN to add single-bit error injection ports.
// Handshake: a word is accepted on any rising edge where dado_valido && pronto;
// upstream must hold dado/dado_valido stable until that edge.
module codifica_hamming_serial
  import hamming_pkg::*;
#(
  parameter int BIT_CICLOS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LARG_DADO-1:0]   dado,
  input  logic                   dado_valido,
`ifdef CODIFICA_INJETA_ERRO_EN
  input  logic                   injeta_erro,
  input  logic [3:0]             posicao_injeta,
`endif
  output logic                   pronto,
  output logic                   tx_bit,
  output logic                   tx_valido,
  output logic                   tx_inicio,
  output logic [LARG_CODIGO-1:0] codigo
);

  localparam logic [7:0] ULT_CICLO = 8'(BIT_CICLOS - 1);
  localparam logic [3:0] IDX_MSB   = 4'(LARG_CODIGO - 1);

  estado_tx_t             r_estado;
  logic [3:0]             r_idx;
  logic [7:0]             r_cnt;
  logic [LARG_CODIGO-1:0] r_codigo;

  logic [LARG_CODIGO-1:0] w_cw_limpo;
  logic [LARG_CODIGO-1:0] w_cw;
  logic                   w_fim_bit;
  logic                   w_ultimo;
  logic                   w_aceita;

  gera_hamming u_gera (
    .i_dado   (dado),
    .o_codigo (w_cw_limpo)
  );

`ifdef CODIFICA_INJETA_ERRO_EN
  // Corruption is applied after parity so the corrector sees a real error.
  always_comb begin
    w_cw = w_cw_limpo;
    if (injeta_erro && (posicao_injeta != 4'hF))
      w_cw = w_cw_limpo ^ (15'(1) << posicao_injeta);
  end
`else
  assign w_cw = w_cw_limpo;
`endif

  assign w_fim_bit = (r_cnt == ULT_CICLO);
  assign w_ultimo  = (r_estado == TRANSMITE) && (r_idx == 4'd0) && w_fim_bit;
  // Accepting in the last cycle of bit 0 lets frames run back to back.
  assign w_aceita  = dado_valido && pronto;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado <= OCIOSO;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_codigo <= '0;
    end else if (w_aceita) begin
      r_estado <= TRANSMITE;
      r_idx    <= IDX_MSB;
      r_cnt    <= '0;
      r_codigo <= w_cw;
    end else if (r_estado == TRANSMITE) begin
      if (w_fim_bit) begin
        r_cnt <= '0;
        if (r_idx == 4'd0) r_estado <= OCIOSO;
        else               r_idx    <= r_idx - 4'd1;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign pronto    = (r_estado == OCIOSO) || w_ultimo;
  assign tx_valido = (r_estado == TRANSMITE);
  assign tx_bit    = (r_estado == TRANSMITE) ? r_codigo[r_idx] : 1'b0;
  assign tx_inicio = (r_estado == TRANSMITE) && (r_idx == IDX_MSB) && (r_cnt == 8'd0);
  assign codigo    = r_codigo;

endmodule
